// File: rtl/fir_phase_scheduler_pkg.sv
// Shared definitions for the polyphase FIR sequencer: FSM encoding and
// phase/tap constants of the 4-phase, 6-tap transmit FIR.
package fir_phase_scheduler_pkg;
   localparam int N_PHASE  = 4;
   localparam int PHASE_W  = 2;
   localparam int FIR_TAPS = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;
endpackage

// File: rtl/fir_phase_scheduler_if.sv
// Ready/valid bit-source link between the PRBS/bit source (master) and the
// FIR sequencer (slave).
interface fir_phase_scheduler_if;
   logic i_bit;
   logic i_bit_valid;
   logic o_bit_ready;

   modport master (output i_bit, output i_bit_valid, input  o_bit_ready);
   modport slave  (input  i_bit, input  i_bit_valid, output o_bit_ready);
endinterface

// File: rtl/fir_phase_scheduler_tick_divider.sv
// Programmable divider producing the FIR sample strobe every CLK_DIV cycles
// while running; cleared synchronously so the first tick lands CLK_DIV later.
module fir_phase_scheduler_tick_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clock,
   input  logic i_reset,
   input  logic clear,
   input  logic run,
   output logic tick
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clock) begin
      if (i_reset || clear)  div_cnt <= '0;
      else if (run) begin
         if (div_cnt == LAST) div_cnt <= '0;
         else                 div_cnt <= div_cnt + CW'(1);
      end
   end

   // With CLK_DIV=1 the counter never leaves 0, so tick follows run.
   assign tick = run && (div_cnt == LAST);
endmodule

// File: rtl/fir_phase_scheduler.sv
// Sequencer for the 4-phase polyphase RC transmit FIR: strobes, per-symbol
// bit fetch, start-up phase alignment, underflow substitution and tail flush.
module fir_phase_scheduler
   import fir_phase_scheduler_pkg::*;
#(
   parameter int   CLK_DIV       = 4,
   parameter int   FLUSH_SYMBOLS = FIR_TAPS,
   parameter logic IDLE_BIT      = 1'b0,
   parameter int   NB_CNT        = 16
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_stop,
   fir_phase_scheduler_if.slave src,
   output logic                o_fir_data,
   output logic                o_fir_enable,
   output logic                o_fir_valid,
   output logic                o_fir_reset,
   output logic [PHASE_W-1:0]  o_phase,
   output logic                o_busy,
   output logic                o_done,
   output logic [NB_CNT-1:0]   o_underflow_cnt
);
   localparam int FW = $clog2(FLUSH_SYMBOLS + 1);

   state_e             state_q, state_d;
   logic               run, tick, boundary, stop_now, fetch, flush_last;
   logic [PHASE_W-1:0] phase_q;
   logic               stop_pend_q, done_q, data_q;
   logic [FW-1:0]      flush_cnt_q;
   logic [NB_CNT-1:0]  ucnt_q;

   assign run = (state_q == ST_RUN) || (state_q == ST_FLUSH);

   fir_phase_scheduler_tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .clock   (clock),
      .i_reset (i_reset),
      .clear   (state_q == ST_ALIGN),
      .run     (run),
      .tick    (tick)
   );

   // A symbol ends on the enable that closes phase 3.
   assign boundary   = tick && (phase_q == PHASE_W'(N_PHASE - 1));
   assign stop_now   = stop_pend_q || i_stop;
   assign fetch      = (state_q == ST_ALIGN) || ((state_q == ST_RUN) && boundary && !stop_now);
   assign flush_last = (state_q == ST_FLUSH) && boundary && (flush_cnt_q == FW'(FLUSH_SYMBOLS - 1));

   always_ff @(posedge clock) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_start) state_d = ST_ALIGN;
         ST_ALIGN: state_d = ST_RUN;
         ST_RUN:   if (boundary && stop_now) state_d = ST_FLUSH;
         ST_FLUSH: if (flush_last) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_fir_enable    = tick;
      o_fir_valid     = boundary;
      src.o_bit_ready = fetch && src.i_bit_valid;
      o_fir_reset     = i_reset || (state_q == ST_ALIGN);
      o_busy          = (state_q != ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         phase_q     <= '0;
         data_q      <= IDLE_BIT;
         ucnt_q      <= '0;
         stop_pend_q <= 1'b0;
         flush_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= flush_last;

         if (state_q == ST_ALIGN) phase_q <= '0;
         else if (tick)           phase_q <= phase_q + PHASE_W'(1);

         // The stop boundary loads the idle bit instead of fetching.
         if (fetch)                              data_q <= src.i_bit_valid ? src.i_bit : IDLE_BIT;
         else if (boundary && state_q == ST_RUN) data_q <= IDLE_BIT;

         if (state_q == ST_ALIGN)
            ucnt_q <= NB_CNT'(!src.i_bit_valid);
         else if (fetch && !src.i_bit_valid && ucnt_q != '1)
            ucnt_q <= ucnt_q + NB_CNT'(1);

         if (state_q == ST_RUN && !boundary && i_stop) stop_pend_q <= 1'b1;
         else if (state_q != ST_RUN || boundary)       stop_pend_q <= 1'b0;

         if (state_q != ST_FLUSH) flush_cnt_q <= '0;
         else if (boundary)       flush_cnt_q <= flush_cnt_q + FW'(1);
      end
   end

   assign o_fir_data      = data_q;
   assign o_phase         = phase_q;
   assign o_done          = done_q;
   assign o_underflow_cnt = ucnt_q;
endmodule
